// File: rtl/ps2_sequence_serializer.sv
// ps2_sequence_serializer
//
// Purpose: queues whole multi-byte escape sequences from the mouse/keyboard
// sequence encoder in a small FIFO and emits them one byte at a time,
// least-significant byte first, over a valid/ready handshake toward the
// UART transmitter. Sequences are never split or interleaved. A sequence
// that arrives while the FIFO is full is lost; the loss is flagged with a
// one-cycle overflow pulse and counted in a saturating 8-bit counter.
//
// Optional feature macro: SERIALIZER_COALESCE_EN
//   undefined (default) : a sequence arriving into a full FIFO is dropped.
//   defined             : it overwrites the newest queued entry instead, so
//                         the latest mouse state always reaches the host.
//
// Ports:
//   clk               in   system clock, rising edge
//   reset             in   asynchronous, active-low reset
//   sequence_in       in   packed sequence, byte 0 = bits [7:0] (sent first)
//   sequence_in_count in   bytes valid in sequence_in, 0 = no push
//   tx_data           out  current byte (0 when not valid)
//   tx_valid          out  tx_data valid
//   tx_ready          in   consumer accepts when tx_valid && tx_ready
//   busy              out  sequence in flight or FIFO non-empty
//   overflow          out  one-cycle pulse after a lost sequence
//   drop_count        out  saturating count of lost sequences

module ps2_sequence_serializer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] sequence_in,
    input  logic [2:0]  sequence_in_count,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        overflow,
    output logic [7:0]  drop_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {
        IDLE,
        SEND
    } state_e;

    // FIFO entry layout: {count[2:0], sequence[31:0]}
    logic [34:0]   mem_q [DEPTH];
    logic [34:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    logic [31:0]   shift_q, shift_d;
    logic [2:0]    remaining_q, remaining_d;
    state_e        state_q, state_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_count_q, drop_count_d;

    logic          fifo_empty;
    logic          fifo_full;
    logic          fifo_pop;
    logic          push_req;
    logic [2:0]    push_count;
    logic [34:0]   head_entry;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    assign push_req   = (sequence_in_count != 3'd0);
    assign push_count = (sequence_in_count > 3'd4) ? 3'd4 : sequence_in_count;
    assign head_entry = mem_q[rd_ptr_q[AW-1:0]];
    assign fifo_pop   = (state_q == IDLE) && !fifo_empty;

    // FIFO write side and loss accounting. The full test uses the pre-edge
    // occupancy, so a pop in the same cycle does not make room for a push.
    always_comb begin
`ifdef SERIALIZER_COALESCE_EN
        logic [AW-1:0] tail_idx;
`endif
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        overflow_d   = 1'b0;
        drop_count_d = drop_count_q;
`ifdef SERIALIZER_COALESCE_EN
        tail_idx     = wr_ptr_q[AW-1:0] - 1'b1;
`endif

        if (push_req) begin
            if (!fifo_full) begin
                mem_d[wr_ptr_q[AW-1:0]] = {push_count, sequence_in};
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end else begin
`ifdef SERIALIZER_COALESCE_EN
                // When full the tail is never the head, so the entry being
                // popped this cycle is never the one overwritten.
                mem_d[tail_idx] = {push_count, sequence_in};
`endif
                overflow_d = 1'b1;
                if (drop_count_q != 8'hFF) begin
                    drop_count_d = drop_count_q + 8'd1;
                end
            end
        end

        if (fifo_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Sequencer: IDLE loads the head sequence into the shift register (one
    // bubble cycle per sequence), SEND presents bytes until the last is taken.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        remaining_d = remaining_q;
        tx_valid    = 1'b0;
        tx_data     = 8'h00;

        case (state_q)
            IDLE: begin
                if (fifo_pop) begin
                    shift_d     = head_entry[31:0];
                    remaining_d = head_entry[34:32];
                    state_d     = SEND;
                end
            end
            SEND: begin
                tx_valid = 1'b1;
                tx_data  = shift_q[7:0];
                if (tx_ready) begin
                    shift_d     = {8'h00, shift_q[31:8]};
                    remaining_d = remaining_q - 3'd1;
                    if (remaining_q == 3'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            shift_q      <= '0;
            remaining_q  <= '0;
            state_q      <= IDLE;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            shift_q      <= shift_d;
            remaining_q  <= remaining_d;
            state_q      <= state_d;
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    assign busy       = (state_q == SEND) | !fifo_empty;
    assign overflow   = overflow_q;
    assign drop_count = drop_count_q;

endmodule

// File: tb/tb_ps2_sequence_serializer.sv
// tb_ps2_sequence_serializer
//
// Directed bench for ps2_sequence_serializer (DEPTH = 4). Expected bytes are
// queued when a sequence is driven and popped as the DUT hands them over.
// Inputs change and outputs are sampled on the falling clock edge.
// Honours SERIALIZER_COALESCE_EN when choosing the expected overflow order.

module tb_ps2_sequence_serializer;

    logic        clk;
    logic        reset;
    logic [31:0] sequence_in;
    logic [2:0]  sequence_in_count;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        overflow;
    logic [7:0]  drop_count;

    logic [7:0]  exp_q [$];
    int          checks   = 0;
    int          failures = 0;

    ps2_sequence_serializer #(.DEPTH(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .sequence_in       (sequence_in),
        .sequence_in_count (sequence_in_count),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .busy              (busy),
        .overflow          (overflow),
        .drop_count        (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck design still ends the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired before the directed sequence finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one sequence for one rising edge and records the bytes it should
    // produce (clamped to four) when it is expected to reach the output.
    task automatic applyStimulus(input logic [31:0] data, input logic [2:0] count, input bit expect_emit);
        int n;
        sequence_in       = data;
        sequence_in_count = count;
        n = (count > 3'd4) ? 4 : int'(count);
        if (expect_emit) begin
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = data[8*i +: 8];
                exp_q.push_back(b);
            end
        end
        tick();
        sequence_in_count = 3'd0;
        sequence_in       = 32'h0;
    endtask

    // Compares every accepted byte against the scoreboard within a cycle budget.
    task automatic drainScoreboard(input string tag, input int budget);
        int cycles;
        cycles = 0;
        while (exp_q.size() > 0 && cycles < budget) begin
            if (tx_valid && tx_ready) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                checkOutput(tag, {24'h0, tx_data}, {24'h0, e});
            end
            tick();
            cycles++;
        end
        checkOutput({tag, "_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_valid"}, {31'h0, tx_valid}, 32'd0);
        checkOutput({tag, "_busy"},  {31'h0, busy},     32'd0);
    endtask

    initial begin
        logic [7:0] ovf_bytes [6];
        ovf_bytes = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hE5, 8'hF6};

        reset             = 1'b0;
        tx_ready          = 1'b0;
        sequence_in       = 32'h0;
        sequence_in_count = 3'd0;
        tick();
        tick();

        // Reset state
        checkOutput("rst_valid",    {31'h0, tx_valid},   32'd0);
        checkOutput("rst_data",     {24'h0, tx_data},    32'd0);
        checkOutput("rst_busy",     {31'h0, busy},       32'd0);
        checkOutput("rst_overflow", {31'h0, overflow},   32'd0);
        checkOutput("rst_drops",    {24'h0, drop_count}, 32'd0);
        reset = 1'b1;
        tick();

        // Single sequence with exact cycle timing
        tx_ready = 1'b1;
        applyStimulus(32'hA5C3A31E, 3'd4, 1'b1);
        checkOutput("single_bubble_valid", {31'h0, tx_valid}, 32'd0);
        checkOutput("single_bubble_busy",  {31'h0, busy},     32'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checkOutput("single_valid", {31'h0, tx_valid}, 32'd1);
            checkOutput("single_data",  {24'h0, tx_data},  {24'h0, e});
            tick();
        end
        checkIdle("single_end");

        // Backpressure: first byte held for ten cycles
        tx_ready = 1'b0;
        applyStimulus(32'hA5C3A31E, 3'd4, 1'b1);
        tick();
        for (int i = 0; i < 10; i++) begin
            checkOutput("bp_hold_valid", {31'h0, tx_valid}, 32'd1);
            checkOutput("bp_hold_data",  {24'h0, tx_data},  {24'h0, exp_q[0]});
            tick();
        end
        tx_ready = 1'b1;
        drainScoreboard("bp_data", 20);
        checkIdle("bp_end");

        // Count edge cases
        applyStimulus(32'hFFFFFFFF, 3'd0, 1'b1);
        tick();
        tick();
        checkIdle("count0");
        applyStimulus(32'h04030201, 3'd6, 1'b1);
        drainScoreboard("count6_data", 20);
        checkIdle("count6_end");
        applyStimulus(32'h0000001E, 3'd1, 1'b1);
        drainScoreboard("count1_data", 20);
        checkIdle("count1_end");

        // Overflow: six single-byte pushes on consecutive edges into DEPTH=4
        tx_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bit emit;
`ifdef SERIALIZER_COALESCE_EN
            emit = (i != 4);
`else
            emit = (i != 5);
`endif
            applyStimulus({24'h0, ovf_bytes[i]}, 3'd1, emit);
            checkOutput("ovf_pulse", {31'h0, overflow}, {31'h0, (i == 5)});
        end
        tick();
        checkOutput("ovf_pulse_end", {31'h0, overflow},   32'd0);
        checkOutput("ovf_drops",     {24'h0, drop_count}, 32'd1);
        tx_ready = 1'b1;
        drainScoreboard("ovf_order", 40);
        checkIdle("ovf_end");
        checkOutput("ovf_drops_after", {24'h0, drop_count}, 32'd1);

        // Asynchronous reset after the second of four bytes
        applyStimulus(32'h44332211, 3'd4, 1'b1);
        tick();
        for (int i = 0; i < 2; i++) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            checkOutput("arst_pre_data", {24'h0, tx_data}, {24'h0, e});
            tick();
        end
        #1;
        reset = 1'b0;
        #1;
        checkOutput("arst_valid", {31'h0, tx_valid},   32'd0);
        checkOutput("arst_data",  {24'h0, tx_data},    32'd0);
        checkOutput("arst_busy",  {31'h0, busy},       32'd0);
        checkOutput("arst_drops", {24'h0, drop_count}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("arst_after_valid", {31'h0, tx_valid}, 32'd0);
        end

        // Saturation: fill the shift register and FIFO, then 300 drops
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            applyStimulus(32'h00000010 + 32'(i), 3'd1, 1'b0);
        end
        checkOutput("sat_prefill_drops", {24'h0, drop_count}, 32'd0);
        for (int i = 0; i < 300; i++) begin
            int want;
            want = (i + 1 > 255) ? 255 : i + 1;
            applyStimulus(32'h00000020, 3'd1, 1'b0);
            checkOutput("sat_pulse", {31'h0, overflow},   32'd1);
            checkOutput("sat_drops", {24'h0, drop_count}, 32'(want));
        end
        tick();
        checkOutput("sat_pulse_end", {31'h0, overflow},   32'd0);
        checkOutput("sat_final",     {24'h0, drop_count}, 32'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
